memory_responder: RTL

Memory-side responder for the CPU datapath's RAM interface. It accepts the ReadRAM/WriteRAM strobes from the control unit, with the address from MAR and write data from MDR. It performs the access on an internal word-addressed RAM after a programmable number of wait states, returns read data for the MDR input mux, and completes a four-phase Done handshake. The control unit must hold a memory state until Done is seen.

---
 rtl/memory_responder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/memory_responder.sv
// ---------------------------------------------------------------------------
// memory_responder
//
// Memory-side responder for the CPU datapath RAM interface. A read or write
// request is sampled in IDLE, held for WAIT_STATES cycles, performed on an
// internal word-addressed RAM, and acknowledged with a four-phase Done
// handshake. Done stays high until both strobes have been seen low.
//
// Parameters:
//   ADDR_BITS    RAM depth is 2**ADDR_BITS words of 32 bits
//   WAIT_STATES  cycles spent in WAIT before the access (0..15)
//
// Ports:
//   Clock     in   system clock, rising edge
//   Reset     in   asynchronous, active-high
//   ReadRAM   in   read request level
//   WriteRAM  in   write request level
//   Address   in   word address (only [ADDR_BITS-1:0] used)
//   DataIn    in   write data
//   DataOut   out  last read data, held until the next read access
//   Done      out  request complete, held until both strobes are low
//   Busy      out  state is not IDLE
//   Error     out  both strobes were sampled high together
// ---------------------------------------------------------------------------
module memory_responder #(
   parameter int ADDR_BITS   = 9,
   parameter int WAIT_STATES = 2
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        ReadRAM,
   input  logic        WriteRAM,
   input  logic [31:0] Address,
   input  logic [31:0] DataIn,
   output logic [31:0] DataOut,
   output logic        Done,
   output logic        Busy,
   output logic        Error
);

   localparam int         DEPTH    = 1 << ADDR_BITS;
   localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   err_q, err_d;
   logic                   op_wr_q;
   logic                   latch_en;
   logic [ADDR_BITS-1:0]   addr_q;
   logic [31:0]            data_q;

   logic [31:0]            mem [0:DEPTH-1];

   // Address bits above the RAM depth are deliberately ignored (aliasing).
   logic                   unused_addr_hi;
   assign unused_addr_hi = ^Address[31:ADDR_BITS];

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      latch_en = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (ReadRAM && WriteRAM) begin
               // Conflicting strobes: acknowledge with Error, touch nothing.
               err_d   = 1'b1;
               state_d = S_DONE;
            end else if (ReadRAM || WriteRAM) begin
               latch_en = 1'b1;
               cnt_d    = WAIT_CNT;
               state_d  = (WAIT_CNT != 4'd0) ? S_WAIT : S_ACCESS;
            end
         end

         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            // <= 1 rather than == 1 so a zero count can never stall here.
            if (cnt_q <= 4'd1) begin
               state_d = S_ACCESS;
            end
         end

         S_ACCESS: begin
            state_d = S_DONE;
         end

         S_DONE: begin
            if (!ReadRAM && !WriteRAM) begin
               err_d   = 1'b0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Control registers and read data
   // -------------------------------------------------------------------------
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
         op_wr_q <= 1'b0;
         DataOut <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         if (latch_en) begin
            op_wr_q <= WriteRAM;
         end
         if ((state_q == S_ACCESS) && !op_wr_q) begin
            DataOut <= mem[addr_q];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Request capture: address and data are frozen at the sampling edge so
   // later bus changes cannot disturb the access in flight.
   // -------------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (latch_en) begin
         addr_q <= Address[ADDR_BITS-1:0];
         data_q <= DataIn;
      end
   end

   // -------------------------------------------------------------------------
   // RAM write: commits only on the ACCESS exit edge. Reset forces IDLE
   // asynchronously, so an access interrupted before this edge never lands.
   // -------------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if ((state_q == S_ACCESS) && op_wr_q) begin
         mem[addr_q] <= data_q;
      end
   end

   assign Done  = (state_q == S_DONE);
   assign Busy  = (state_q != S_IDLE);
   assign Error = err_q;

endmodule
